inst_line_server: RTL

Memory-side responder for the instruction cache line-fill port. It accepts a line read request (`addr_i`, `rd_i`), fetches the eight 32-bit words of the 32-byte line from a word-wide memory port, assembles them into a 256-bit line, and returns it with a one-cycle `ack_o` pulse. It sits between `inst_cache` (`addr_o`/`rd_o`/`data_i`/`ack_i`) and the shared word memory.

---
 rtl/inst_line_server.sv | 123 ++++++++++++
 1 files changed

// File: rtl/inst_line_server.sv
// Line-fill responder: gathers a 32-byte line as eight ascending word reads
// and hands it back to the instruction cache with a one-cycle ack pulse.
module inst_line_server #(
  parameter int LINE_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               addr_i,
  input  logic                      rd_i,
  output logic [32*LINE_WORDS-1:0]  data_o,
  output logic                      ack_o,
  output logic [31:0]               mem_addr_o,
  output logic                      mem_rd_o,
  input  logic [31:0]               mem_data_i,
  input  logic                      mem_valid_i
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam int OW = CW + 2;
  localparam int BW = 32 - OW;
  localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t                          r_state, w_state_next;
  logic [CW-1:0]                   r_count, w_count_next;
  logic [BW-1:0]                   r_base, w_base_next;
  logic [31:0]                     r_mem_addr, w_mem_addr_next;
  logic                            r_mem_rd, w_mem_rd_next;
  logic                            r_ack, w_ack_next;
  logic                            r_rel, w_rel_next;
  logic [LINE_WORDS-1:0][31:0]     r_data;
  logic [LINE_WORDS-1:0]           w_word_we;
  logic [CW-1:0]                   w_count_inc;
  logic                            w_unused;

  assign w_count_inc = r_count + 1'b1;
  assign w_unused    = ^addr_i[OW-1:0];

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_base_next     = r_base;
    w_mem_addr_next = r_mem_addr;
    w_mem_rd_next   = r_mem_rd;
    w_ack_next      = 1'b0;
    w_rel_next      = r_rel;
    w_word_we       = '0;
    case (r_state)
      S_IDLE: begin
        if (rd_i) begin
          w_base_next     = addr_i[31:OW];
          w_count_next    = '0;
          w_mem_addr_next = {addr_i[31:OW], {OW{1'b0}}};
          w_mem_rd_next   = 1'b1;
          w_state_next    = S_FILL;
        end
      end
      S_FILL: begin
        // A dropped request wins over a word arriving in the same cycle.
        if (!rd_i) begin
          w_mem_rd_next = 1'b0;
          w_state_next  = S_IDLE;
        end else if (mem_valid_i) begin
          w_word_we[r_count] = 1'b1;
          w_count_next       = w_count_inc;
          w_mem_addr_next    = {r_base, w_count_inc, 2'b00};
          if (r_count == LAST_WORD) begin
            w_mem_rd_next = 1'b0;
            w_ack_next    = 1'b1;
            w_state_next  = S_ACK;
          end
        end
      end
      S_ACK: begin
        w_rel_next   = !rd_i;
        w_state_next = S_RELEASE;
      end
      S_RELEASE: begin
        // Hold here until the cache lets go of rd_i so a stale level cannot refetch.
        if (r_rel || !rd_i) begin
          w_rel_next   = 1'b0;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_base     <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_ack      <= 1'b0;
      r_rel      <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_base     <= w_base_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_rd   <= w_mem_rd_next;
      r_ack      <= w_ack_next;
      r_rel      <= w_rel_next;
      for (int k = 0; k < LINE_WORDS; k++) begin
        if (w_word_we[k]) r_data[k] <= mem_data_i;
      end
    end
  end

  assign data_o     = r_data;
  assign ack_o      = r_ack;
  assign mem_addr_o = r_mem_addr;
  assign mem_rd_o   = r_mem_rd;

endmodule
